// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Bundles the two requester channels and the shared response
//            channel of the two-port ALU arbiter.
// Ports    : (none -- signal bundle only)
//            req0_* / req1_* : valid/ready handshake, operands a/b, opcode op
//            rsp_*           : valid/ready handshake, owner id, result, flags
// Modports : master -- request generator / response consumer
//            slave  -- the arbiter itself
// Revision : 1.0  initial release
// ============================================================================
interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [3:0]  req0_op;

   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [3:0]  req1_op;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_out;
   logic        rsp_zf;
   logic        rsp_cf;
   logic        rsp_of;
   logic        rsp_sf;
   logic        rsp_err;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_out, rsp_zf, rsp_cf, rsp_of, rsp_sf, rsp_err,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_out, rsp_zf, rsp_cf, rsp_of, rsp_sf, rsp_err,
      input  rsp_ready
   );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter sharing one 32-bit ALU between two
//            requesters. IDLE grants and latches, EXEC computes and registers
//            the result, RESP holds it until the consumer accepts.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - alu_arbiter_if.slave (requests in, response out)
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [3:0]  op_q, op_d;
   logic        id_q, id_d;

   logic [31:0] rsp_out_q, rsp_out_d;
   logic        rsp_id_q, rsp_id_d;
   logic        rsp_zf_q, rsp_zf_d;
   logic        rsp_cf_q, rsp_cf_d;
   logic        rsp_of_q, rsp_of_d;
   logic        rsp_sf_q, rsp_sf_d;
   logic        rsp_err_q, rsp_err_d;

   logic        grant_id;
   logic        ready0, ready1;

   logic [31:0] alu_out;
   logic        alu_cf, alu_of, alu_err;
   logic [4:0]  shamt;

   // ALU: operates only on the latched operands, so requester inputs may
   // change freely once the operation has been accepted.
   always_comb begin
      alu_out = 32'd0;
      alu_cf  = 1'b0;
      alu_of  = 1'b0;
      alu_err = 1'b0;
      shamt   = b_q[4:0];
      case (op_q)
         4'b0000: begin
            {alu_cf, alu_out} = {1'b0, a_q} + {1'b0, b_q};
            alu_of = (a_q[31] == b_q[31]) && (alu_out[31] != a_q[31]);
         end
         4'b0001: alu_out = a_q << shamt;
         4'b0010: alu_out = {31'd0, ($signed(a_q) < $signed(b_q))};
         4'b0011: alu_out = {31'd0, (a_q < b_q)};
         4'b0100: alu_out = a_q ^ b_q;
         4'b0101: alu_out = a_q >> shamt;
         4'b0110: alu_out = a_q | b_q;
         4'b0111: alu_out = a_q & b_q;
         4'b1000: begin
            alu_out = a_q - b_q;
            alu_cf  = (a_q < b_q);
            alu_of  = (a_q[31] != b_q[31]) && (alu_out[31] != a_q[31]);
         end
         4'b1101: alu_out = $unsigned($signed(a_q) >>> shamt);
         4'b1010: begin
            {alu_cf, alu_out} = {1'b0, a_q} + 33'd1;
            alu_of = (a_q == 32'h7FFF_FFFF);
         end
         4'b1011: begin
            alu_out = a_q - 32'd1;
            alu_cf  = (a_q == 32'd0);
            alu_of  = (a_q == 32'h8000_0000);
         end
         default: alu_err = 1'b1;   // result stays 0, so zf comes out as 1
      endcase
   end

   // With both valid the pointer decides; otherwise the lone valid one wins.
   assign grant_id = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      id_d       = id_q;
      rsp_out_d  = rsp_out_q;
      rsp_id_d   = rsp_id_q;
      rsp_zf_d   = rsp_zf_q;
      rsp_cf_d   = rsp_cf_q;
      rsp_of_d   = rsp_of_q;
      rsp_sf_d   = rsp_sf_q;
      rsp_err_d  = rsp_err_q;
      ready0     = 1'b0;
      ready1     = 1'b0;
      case (state_q)
         IDLE: begin
            // ready is suppressed under reset so nothing is accepted then
            if ((bus.req0_valid || bus.req1_valid) && !rst) begin
               ready0  = ~grant_id;
               ready1  = grant_id;
               a_d     = grant_id ? bus.req1_a  : bus.req0_a;
               b_d     = grant_id ? bus.req1_b  : bus.req0_b;
               op_d    = grant_id ? bus.req1_op : bus.req0_op;
               id_d    = grant_id;
               ptr_d   = ~grant_id;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_out_d = alu_out;
            rsp_id_d  = id_q;
            rsp_zf_d  = (alu_out == 32'd0);
            rsp_sf_d  = alu_out[31];
            rsp_cf_d  = alu_cf;
            rsp_of_d  = alu_of;
            rsp_err_d = alu_err;
            state_d   = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= 1'b0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         op_q      <= 4'd0;
         id_q      <= 1'b0;
         rsp_out_q <= 32'd0;
         rsp_id_q  <= 1'b0;
         rsp_zf_q  <= 1'b0;
         rsp_cf_q  <= 1'b0;
         rsp_of_q  <= 1'b0;
         rsp_sf_q  <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         id_q      <= id_d;
         rsp_out_q <= rsp_out_d;
         rsp_id_q  <= rsp_id_d;
         rsp_zf_q  <= rsp_zf_d;
         rsp_cf_q  <= rsp_cf_d;
         rsp_of_q  <= rsp_of_d;
         rsp_sf_q  <= rsp_sf_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.rsp_valid  = (state_q == RESP);
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_out    = rsp_out_q;
   assign bus.rsp_zf     = rsp_zf_q;
   assign bus.rsp_cf     = rsp_cf_q;
   assign bus.rsp_of     = rsp_of_q;
   assign bus.rsp_sf     = rsp_sf_q;
   assign bus.rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter.
// Ports    : (none)
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   alu_arbiter_if bus();

   alu_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h required %h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {bus.rsp_zf, bus.rsp_cf, bus.rsp_of, bus.rsp_sf, bus.rsp_err};
   endfunction

   function automatic logic [1:0] readies();
      return {bus.req1_ready, bus.req0_ready};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated operation from IDLE with rsp_ready=1. Operands are
   // scrambled right after acceptance to show they are not re-sampled.
   // exp_flags = {zf, cf, of, sf, err}
   task automatic do_op(input string tag, input logic id, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] exp_out, input logic [4:0] exp_flags);
      bus.rsp_ready = 1'b1;
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
      end
      #1;
      chk({tag, "_grant"}, {30'd0, readies()}, id ? 32'd2 : 32'd1);
      tick();
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_a = 32'hDEAD_BEEF; bus.req0_b = 32'h1234_5678; bus.req0_op = 4'b0110;
      bus.req1_a = 32'hDEAD_BEEF; bus.req1_b = 32'h1234_5678; bus.req1_op = 4'b0110;
      chk({tag, "_exec_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
      tick();
      chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      chk({tag, "_out"},   bus.rsp_out, exp_out);
      chk({tag, "_flags"}, {27'd0, flags()}, {27'd0, exp_flags});
      chk({tag, "_id"},    {31'd0, bus.rsp_id}, {31'd0, id});
      tick();
      chk({tag, "_done"},  {31'd0, bus.rsp_valid}, 32'd0);
   endtask

   initial begin
      int          g_cnt;
      int          r_cnt;
      logic [1:0]  g_ord [4];
      errors = 0;
      checks = 0;
      g_cnt  = 0;
      r_cnt  = 0;

      rst = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_op = 4'd0;
      bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_op = 4'd0;
      bus.rsp_ready  = 1'b1;
      tick();
      tick();

      // reset state: nothing accepted, response registers cleared
      chk("rst_ready",  {30'd0, readies()}, 32'd0);
      chk("rst_valid",  {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_out",    bus.rsp_out, 32'd0);
      chk("rst_flags",  {27'd0, flags()}, 32'd0);
      chk("rst_id",     {31'd0, bus.rsp_id}, 32'd0);
      bus.req0_valid = 1'b0;
      rst = 1'b0;
      tick();

      // single ADD with carry-out and zero result
      do_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 5'b11000);
      // overflow and compares
      do_op("inc_ovf",  1'b1, 32'h7FFF_FFFF, 32'd0, 4'b1010, 32'h8000_0000, 5'b00110);
      do_op("slt",      1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1, 5'b00000);
      do_op("sltu",     1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0011, 32'd0, 5'b10000);
      // unsupported opcode, then a good ADD on the same requester
      do_op("bad_op",   1'b1, 32'h1234_5678, 32'h9, 4'b1111, 32'd0, 5'b10001);
      do_op("add_ok",   1'b1, 32'd2, 32'd3, 4'b0000, 32'd5, 5'b00000);
      // shift boundaries and misc ops
      do_op("sll_0",    1'b0, 32'h1234_5678, 32'h20, 4'b0001, 32'h1234_5678, 5'b00000);
      do_op("srl_31",   1'b1, 32'h8000_0000, 32'd31, 4'b0101, 32'd1, 5'b00000);
      do_op("dec_0",    1'b0, 32'd0, 32'd0, 4'b1011, 32'hFFFF_FFFF, 5'b01010);
      do_op("xor",      1'b1, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 4'b0100, 32'h5A5A_5A5A, 5'b00000);

      // contention from a fresh reset: grants must alternate 0,1,0,1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.rsp_ready  = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 32'd5;          bus.req0_b = 32'd7; bus.req0_op = 4'b1000;
      bus.req1_valid = 1'b1; bus.req1_a = 32'h8000_0000;  bus.req1_b = 32'd4; bus.req1_op = 4'b1101;
      #1;
      for (int i = 0; i < 12; i++) begin
         if ((bus.req0_ready || bus.req1_ready) && g_cnt < 4) begin
            g_ord[g_cnt] = readies();
            g_cnt++;
         end
         if (bus.rsp_valid) begin
            r_cnt++;
            if (bus.rsp_id) begin
               chk("cont_r1_out",   bus.rsp_out, 32'hF800_0000);
               chk("cont_r1_flags", {27'd0, flags()}, 32'b00010);
            end else begin
               chk("cont_r0_out",   bus.rsp_out, 32'hFFFF_FFFE);
               chk("cont_r0_flags", {27'd0, flags()}, 32'b01010);
            end
         end
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      chk("cont_grants", g_cnt, 32'd4);
      chk("cont_resps",  r_cnt, 32'd4);
      chk("cont_order",  {24'd0, g_ord[0], g_ord[1], g_ord[2], g_ord[3]}, 32'b01_10_01_10);

      // backpressure: result held for 5 cycles, no grants meanwhile
      bus.req1_valid = 1'b1; bus.req1_a = 32'hF0F0_F0F0; bus.req1_b = 32'hFF00_FF00; bus.req1_op = 4'b0111;
      bus.rsp_ready  = 1'b0;
      #1;
      chk("bp_grant", {30'd0, readies()}, 32'd2);
      tick();
      bus.req1_valid = 1'b0;
      bus.req0_valid = 1'b1;
      chk("bp_exec_ready", {30'd0, readies()}, 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
         chk("bp_out",   bus.rsp_out, 32'hF000_F000);
         chk("bp_flags", {27'd0, flags()}, 32'b00010);
         chk("bp_id",    {31'd0, bus.rsp_id}, 32'd1);
         chk("bp_ready", {30'd0, readies()}, 32'd0);
         if (i < 4) tick();
      end
      bus.req0_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      tick();
      chk("bp_done", {31'd0, bus.rsp_valid}, 32'd0);

      // reset during EXEC: transaction dropped, pointer back to 0
      bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_op = 4'b0000;
      #1;
      chk("rx_grant", {30'd0, readies()}, 32'd1);
      tick();
      bus.req0_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rx_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
         tick();
      end
      bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd4; bus.req0_op = 4'b1000;
      bus.req1_valid = 1'b1;
      #1;
      chk("rx_ptr0_grant", {30'd0, readies()}, 32'd1);
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick();
      chk("rx_out",   bus.rsp_out, 32'd5);
      chk("rx_flags", {27'd0, flags()}, 32'b00000);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
